// File: rtl/pi_off_div_ctl_pkg.sv
// Shared definitions for the PI off-time controller: FSM states, default
// gains/limits and the internal signed arithmetic width.
package pi_off_div_ctl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ERR    = 3'd1,
    CALC   = 3'd2,
    CLAMP  = 3'd3,
    UPDATE = 3'd4
  } state_t;

  // Wide enough that error gain, integrator term and nominal offset never wrap.
  localparam int ARITH_W = 26;

  localparam int KP_SHIFT_DEF      = 2;
  localparam int KI_SHIFT_DEF      = 4;
  localparam int INT_LIM_DEF       = 4096;
  localparam int OFF_NOM_DEF       = 100;
  localparam int OFF_MIN_DEF       = 20;
  localparam int OFF_MAX_DEF       = 400;
  localparam int START_SAMPLES_DEF = 8;

endpackage

// File: rtl/pi_sat_clamp.sv
// Combinational signed saturation of din into the closed range [lo, hi].
module pi_sat_clamp #(
  parameter int W = 26
) (
  input  logic signed [W-1:0] din,
  input  logic signed [W-1:0] lo,
  input  logic signed [W-1:0] hi,
  output logic signed [W-1:0] dout
);

  always_comb begin
    if (din < lo)      dout = lo;
    else if (din > hi) dout = hi;
    else               dout = din;
  end

endmodule

// File: rtl/pi_off_div_ctl.sv
// PI loop turning ADC samples into a PWM off count, one sample per five cycles,
// with a fixed-off-count soft-start period after reset or enable.
module pi_off_div_ctl
  import pi_off_div_ctl_pkg::*;
#(
  parameter int CNT_WIDTH     = 16,
  parameter int ADC_WIDTH     = 12,
  parameter int KP_SHIFT      = KP_SHIFT_DEF,
  parameter int KI_SHIFT      = KI_SHIFT_DEF,
  parameter int INT_LIM       = INT_LIM_DEF,
  parameter int OFF_NOM       = OFF_NOM_DEF,
  parameter int OFF_MIN       = OFF_MIN_DEF,
  parameter int OFF_MAX       = OFF_MAX_DEF,
  parameter int START_SAMPLES = START_SAMPLES_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 adc_valid,
  input  logic [ADC_WIDTH-1:0] adc_data,
  input  logic [ADC_WIDTH-1:0] setpoint,
  output logic                 adc_ready,
  output logic [CNT_WIDTH-1:0] off_div,
  output logic                 pwm_chg,
  output logic                 act_ctl
);

  if (OFF_MIN > OFF_NOM || OFF_NOM > OFF_MAX || START_SAMPLES < 1) begin : g_param_chk
    $error("pi_off_div_ctl: need OFF_MIN <= OFF_NOM <= OFF_MAX and START_SAMPLES >= 1");
  end

  localparam int SS_W = $clog2(START_SAMPLES + 1);

  typedef logic signed [ARITH_W-1:0] arith_t;

  localparam arith_t INT_HI  = arith_t'(INT_LIM);
  localparam arith_t INT_LO  = -arith_t'(INT_LIM);
  localparam arith_t NOM_S   = arith_t'(OFF_NOM);
  localparam arith_t MIN_S   = arith_t'(OFF_MIN);
  localparam arith_t MAX_S   = arith_t'(OFF_MAX);
  localparam logic [CNT_WIDTH-1:0] OFF_MAX_C = CNT_WIDTH'(OFF_MAX);
  localparam logic [SS_W-1:0]      SS_DONE   = SS_W'(START_SAMPLES);

  state_t state, state_next;
  logic   accept;

  logic [ADC_WIDTH-1:0]     adc_p0, sp_p0;
  logic signed [ADC_WIDTH:0] err_c, err_p1;
  arith_t err_x, err_p1_x;
  arith_t integ, integ_sum, integ_sat;
  arith_t term_c, cand_p2, clamp_c, res_p3;
  logic [SS_W-1:0] ss_cnt;

  assign accept = adc_valid && adc_ready;

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // FSM: next state; dropping enable abandons any in-flight calculation
  always_comb begin
    state_next = state;
    if (!enable) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_next = ERR;
        ERR:     state_next = CALC;
        CALC:    state_next = CLAMP;
        CLAMP:   state_next = UPDATE;
        UPDATE:  state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    adc_ready = (state == IDLE) && enable && !rst;
  end

  assign err_c     = $signed({1'b0, sp_p0}) - $signed({1'b0, adc_p0});
  assign err_x     = {{(ARITH_W-ADC_WIDTH-1){err_c[ADC_WIDTH]}}, err_c};
  assign err_p1_x  = {{(ARITH_W-ADC_WIDTH-1){err_p1[ADC_WIDTH]}}, err_p1};
  assign integ_sum = integ + err_x;
  assign term_c    = (err_p1_x <<< KP_SHIFT) + (integ >>> KI_SHIFT);

  pi_sat_clamp #(.W(ARITH_W)) u_int_sat (
    .din  (integ_sum),
    .lo   (INT_LO),
    .hi   (INT_HI),
    .dout (integ_sat)
  );

  pi_sat_clamp #(.W(ARITH_W)) u_out_clamp (
    .din  (cand_p2),
    .lo   (MIN_S),
    .hi   (MAX_S),
    .dout (clamp_c)
  );

  // p0 capture -> p1 error -> p2 candidate -> p3 clamped result
  always_ff @(posedge clk) begin
    if (accept)           begin adc_p0 <= adc_data; sp_p0 <= setpoint; end
    if (state == ERR)     err_p1  <= err_c;
    if (state == CALC)    cand_p2 <= NOM_S - term_c;
    if (state == CLAMP)   res_p3  <= act_ctl ? MAX_S : clamp_c;
  end

  // Loop state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      integ   <= '0;
      ss_cnt  <= '0;
      act_ctl <= 1'b1;
      off_div <= OFF_MAX_C;
      pwm_chg <= 1'b0;
    end else if (!enable) begin
      integ   <= '0;
      ss_cnt  <= '0;
      act_ctl <= 1'b1;
      off_div <= OFF_MAX_C;
      pwm_chg <= 1'b0;
    end else begin
      pwm_chg <= 1'b0;
      if (state == ERR && !act_ctl) integ <= integ_sat;
      if (state == UPDATE) begin
        off_div <= CNT_WIDTH'(res_p3);
        pwm_chg <= 1'b1;
        if (act_ctl) begin
          ss_cnt <= ss_cnt + SS_W'(1);
          if (ss_cnt + SS_W'(1) == SS_DONE) act_ctl <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pi_off_div_ctl.sv
// Directed and randomized bench for pi_off_div_ctl against a plain-integer
// model of the PI law, soft-start count and saturation limits.
module tb_pi_off_div_ctl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        adc_valid = 1'b0;
  logic [11:0] adc_data = '0;
  logic [11:0] setpoint = '0;
  logic        adc_ready;
  logic [15:0] off_div;
  logic        pwm_chg;
  logic        act_ctl;

  int checks = 0;
  int errors = 0;

  int m_integ = 0;
  int m_cnt   = 0;
  int m_off   = 400;
  bit m_act   = 1'b1;

  pi_off_div_ctl dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .adc_valid (adc_valid),
    .adc_data  (adc_data),
    .setpoint  (setpoint),
    .adc_ready (adc_ready),
    .off_div   (off_div),
    .pwm_chg   (pwm_chg),
    .act_ctl   (act_ctl)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int floor_div(input int v, input int d);
    return (v >= 0) ? v / d : -((-v + d - 1) / d);
  endfunction

  task automatic model_reset();
    m_integ = 0; m_cnt = 0; m_act = 1'b1; m_off = 400;
  endtask

  task automatic model_step(input int sp, input int adc);
    int e, t, cand;
    e = sp - adc;
    if (!m_act) begin
      m_integ = m_integ + e;
      if (m_integ > 4096)  m_integ = 4096;
      if (m_integ < -4096) m_integ = -4096;
    end
    t    = e * 4 + floor_div(m_integ, 16);
    cand = 100 - t;
    if (m_act)            m_off = 400;
    else if (cand < 20)   m_off = 20;
    else if (cand > 400)  m_off = 400;
    else                  m_off = cand;
    if (m_act) begin
      m_cnt++;
      if (m_cnt == 8) m_act = 1'b0;
    end
  endtask

  // One full transaction: the pulse must land exactly 4 edges after the accept edge.
  task automatic do_sample(input int sp, input int adc);
    logic early;
    early = 1'b0;
    @(negedge clk);
    chk("adc_ready_idle", adc_ready, 1);
    setpoint = 12'(sp); adc_data = 12'(adc); adc_valid = 1'b1;
    @(posedge clk); #1;
    adc_valid = 1'b0;
    model_step(sp, adc);
    for (int k = 1; k < 4; k++) begin
      @(posedge clk); #1;
      early = early | pwm_chg;
    end
    chk("pwm_chg_early", early, 0);
    @(posedge clk); #1;
    chk("pwm_chg_pulse", pwm_chg, 1);
    chk("off_div", off_div, m_off);
    chk("act_ctl", act_ctl, m_act);
    chk("integ", dut.integ, m_integ);
    @(posedge clk); #1;
    chk("pwm_chg_one_cycle", pwm_chg, 0);
  endtask

  initial begin
    int acc, pul;
    logic seen;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_off_div", off_div, 400);
    chk("rst_pwm_chg", pwm_chg, 0);
    chk("rst_act_ctl", act_ctl, 1);
    chk("rst_adc_ready", adc_ready, 0);
    @(negedge clk);
    rst = 1'b0; enable = 1'b1;
    #1;
    chk("ready_after_rst", adc_ready, 1);

    // Soft-start: eight samples at fixed OFF_MAX, integrator frozen
    for (int i = 0; i < 8; i++) do_sample(2000, 1990);
    chk("ss_done_act", act_ctl, 0);

    // First closed-loop update: e=10 -> off 60
    do_sample(2000, 1990);
    chk("closed_loop_60", off_div, 60);

    for (int i = 0; i < 10; i++) do_sample(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)));

    // Positive integrator saturation with min clamp
    for (int i = 0; i < 5; i++) do_sample(2000, 0);
    chk("integ_pos_lim", dut.integ, 4096);
    chk("off_min", off_div, 20);

    // Negative integrator saturation with max clamp
    for (int i = 0; i < 6; i++) do_sample(0, 4095);
    chk("integ_neg_lim", dut.integ, -4096);

    for (int i = 0; i < 6; i++) do_sample(int'($urandom_range(1500, 2500)), int'($urandom_range(1500, 2500)));

    do_sample(2000, 4095);
    chk("off_max", off_div, 400);

    // adc_valid held for 20 cycles: one accept per 5-cycle transaction
    acc = 0; pul = 0;
    @(negedge clk);
    setpoint = 12'd2000; adc_data = 12'd4095; adc_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (adc_ready) acc++;
      @(posedge clk); #1;
      if (pwm_chg) pul++;
      @(negedge clk);
    end
    adc_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (pwm_chg) pul++;
    end
    for (int i = 0; i < 4; i++) model_step(2000, 4095);
    chk("held_accepts", acc, 4);
    chk("held_pulses", pul, 4);
    chk("held_off_div", off_div, m_off);
    chk("held_integ", dut.integ, m_integ);

    do_sample(2000, 1995);

    // enable dropped during CALC discards the calculation
    @(negedge clk);
    setpoint = 12'd2000; adc_data = 12'd1000; adc_valid = 1'b1;
    @(posedge clk); #1;
    adc_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    @(posedge clk); #1;
    model_reset();
    chk("en_drop_off_div", off_div, 400);
    chk("en_drop_act", act_ctl, 1);
    chk("en_drop_pwm", pwm_chg, 0);
    chk("en_drop_integ", dut.integ, 0);
    seen = 1'b0;
    repeat (6) begin @(posedge clk); #1; seen = seen | pwm_chg; end
    chk("en_drop_no_pulse", seen, 0);
    @(negedge clk);
    enable = 1'b1;

    // enable falling during UPDATE suppresses that pulse
    @(negedge clk);
    setpoint = 12'd2000; adc_data = 12'd1990; adc_valid = 1'b1;
    @(posedge clk); #1;
    adc_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    @(posedge clk); #1;
    chk("upd_drop_pwm", pwm_chg, 0);
    chk("upd_drop_off_div", off_div, 400);
    @(negedge clk);
    enable = 1'b1;

    // Soft-start restarts from zero after enable returns
    for (int i = 0; i < 8; i++) do_sample(2000, 1990);
    do_sample(2000, 1995);

    // rst asserted during CLAMP
    @(negedge clk);
    setpoint = 12'd2000; adc_data = 12'd1900; adc_valid = 1'b1;
    @(posedge clk); #1;
    adc_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_mid_off_div", off_div, 400);
    chk("rst_mid_pwm", pwm_chg, 0);
    chk("rst_mid_act", act_ctl, 1);
    chk("rst_mid_ready", adc_ready, 0);
    chk("rst_mid_integ", dut.integ, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin @(posedge clk); #1; seen = seen | pwm_chg; end
    chk("rst_rel_no_pulse", seen, 0);
    do_sample(2000, 1900);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pi_off_div_ctl.md
PI_OFF_DIV_CTL -- requirements
Module: pi_off_div_ctl

Interface
REQ-001 Parameters SHALL be: CNT_WIDTH 16, off-count width; ADC_WIDTH 12, sample width; KP_SHIFT 2, proportional gain as left shift; KI_SHIFT 4, integral gain as right shift; INT_LIM 4096, integrator magnitude limit; OFF_NOM 100, nominal off count; OFF_MIN 20, minimum off count; OFF_MAX 400, maximum off count; START_SAMPLES 8, soft-start update count.
REQ-002 clk  input  1  single clock; all state on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 enable  input  1  loop enable; low forces the idle/soft-start condition.
REQ-005 adc_valid  input  1  ADC sample valid.
REQ-006 adc_data  input  ADC_WIDTH  unsigned ADC sample.
REQ-007 setpoint  input  ADC_WIDTH  unsigned target; sampled with adc_data on accept.
REQ-008 adc_ready  output  1  block can accept a sample.
REQ-009 off_div  output  CNT_WIDTH  registered off count for the downstream PWM generator.
REQ-010 pwm_chg  output  1  one-cycle strobe; off_div is valid and stable in that cycle.
REQ-011 act_ctl  output  1  soft-start active; downstream uses its start off count while high.

Function
REQ-012 FSM states SHALL be IDLE, ERR, CALC, CLAMP, UPDATE; IDLE->ERR on accept, then one state per cycle, UPDATE->IDLE.
REQ-013 adc_ready SHALL equal (state==IDLE && enable); accept = adc_valid && adc_ready; adc_data and setpoint captured on accept.
REQ-014 ERR: e = setpoint - adc_data as signed ADC_WIDTH+1; integ_next = integ + e saturated to [-INT_LIM, +INT_LIM]; integ updated only when act_ctl==0.
REQ-015 CALC: t = (e <<< KP_SHIFT) + (integ >>> KI_SHIFT), arithmetic shift; cand = OFF_NOM - t; all in signed 26-bit, no wrap.
REQ-016 CLAMP: res = OFF_MIN if cand < OFF_MIN, OFF_MAX if cand > OFF_MAX, else cand; while act_ctl==1, res = OFF_MAX regardless of cand.
REQ-017 UPDATE: off_div <= res and pwm_chg <= 1 on the same edge; pwm_chg high exactly one cycle, 4 cycles after the accept cycle.
REQ-018 Throughput: at most one sample per 5 cycles; adc_valid held while adc_ready low SHALL NOT be lost or double-accepted.
REQ-019 Soft-start counter SHALL increment at each UPDATE while act_ctl==1; act_ctl SHALL drop on the edge ending the UPDATE whose count reaches START_SAMPLES, so the next update is the first closed-loop one.
REQ-020 enable low in any state SHALL, next edge: state IDLE, integ 0, soft-start count 0, act_ctl 1, off_div OFF_MAX, no pwm_chg (an in-flight calculation is discarded).
REQ-021 enable falling in the same cycle as UPDATE SHALL suppress that pwm_chg; enable rising restarts soft-start from count 0.
REQ-022 Integrator at +/-INT_LIM SHALL hold at the limit (no wrap) for further same-sign error.

Reset
REQ-023 rst high SHALL asynchronously force: state IDLE, integ 0, count 0, off_div OFF_MAX, pwm_chg 0, act_ctl 1, adc_ready 0 (while rst high).
REQ-024 Reset release mid-sample SHALL NOT produce pwm_chg until a new accept completes.

Structure
REQ-025 Shared package SHALL hold the FSM state enumeration, default gain/limit constants and the 26-bit arithmetic width constant.
REQ-026 One sub-module, pi_sat_clamp (combinational signed saturate to [lo, hi]), SHALL be used for both the integrator limit and the output clamp.
REQ-027 Verify OFF_MIN <= OFF_NOM <= OFF_MAX and START_SAMPLES >= 1 at elaboration.

Verification
REQ-028 Reset, enable=1, 8 samples setpoint 2000 adc 1990 -> 8 pwm_chg pulses with off_div 400, act_ctl falls after the 8th, integ stays 0.
REQ-029 After soft-start, setpoint 2000 adc 1990 -> e=10, integ 10, t=40, off_div 60, pwm_chg 4 cycles after accept.
REQ-030 After soft-start, adc 0 setpoint 2000 repeated 5 times -> off_div 20 each; integ climbs to and holds 4096.
REQ-031 After soft-start, adc 4095 setpoint 2000 -> off_div 400; adc_valid held high 20 cycles -> exactly 4 accepts, 4 pulses.
REQ-032 enable dropped in CALC -> no pwm_chg, off_div 400, act_ctl 1, next sample restarts soft-start count.
REQ-033 rst asserted in CLAMP -> outputs at reset values immediately; no pwm_chg after release without a new sample.
